// File: rtl/itf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : itf_pkg                                                          |
// | Shared state encoding, command field offsets and beat sizing for the ITF.  |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
package itf_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RD    = 2'd1;
    localparam logic [1:0] WR    = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam int INOUT_LSB = 0;
    localparam int ADDR_LSB  = 1;
    localparam int NUM_LSB   = 33;

    function automatic int bytes_per_beat(input int port_width);
        return port_width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/itf_dram_responder_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : FIFO_FWFT                                                         |
// | First-word-fall-through FIFO with synchronous flush; head is always on     |
// | o_dout while not empty. Rev 1.0                                            |
// +----------------------------------------------------------------------------+
module FIFO_FWFT #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count
);
    localparam int                c_depth    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_cnt_full = (ADDR_WIDTH+1)'(c_depth);

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    // A push into a full FIFO is allowed when the head leaves on the same edge.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != c_cnt_full) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + ADDR_WIDTH'(1);
            if (w_do_pop)  r_rptr <= r_rptr + ADDR_WIDTH'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/itf_dram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : itf_dram_responder                                                |
// | Off-chip end of the GIC<->ITF port: DRAM reads streamed to the chip        |
// | (IN2CHIP) and chip beats written to DRAM (OUT2OFF).                        |
// | Option : ITFRSP_LEN_CHECK_EN adds the sticky ErrLen beat-count check.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module itf_dram_responder #(
    parameter int PORT_WIDTH      = 128,
    parameter int SRAM_WIDTH      = 256,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int NUM_WIDTH       = 16,
    parameter int FIFO_AW         = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       GICITF_CmdVld,
    input  logic [PORT_WIDTH-1:0]      GICITF_Dat,
    input  logic                       GICITF_DatVld,
    input  logic                       GICITF_DatLast,
    output logic                       ITFGIC_DatRdy,
    output logic [PORT_WIDTH-1:0]      ITFGIC_Dat,
    output logic                       ITFGIC_DatVld,
    output logic                       ITFGIC_DatLast,
    input  logic                       GICITF_DatRdy,
    output logic [DRAM_ADDR_WIDTH-1:0] DRAM_RdAddr,
    output logic                       DRAM_RdAddrVld,
    input  logic                       DRAM_RdAddrRdy,
    input  logic [PORT_WIDTH-1:0]      DRAM_RdDat,
    input  logic                       DRAM_RdDatVld,
    output logic [DRAM_ADDR_WIDTH-1:0] DRAM_WrAddr,
    output logic [PORT_WIDTH-1:0]      DRAM_WrDat,
    output logic                       DRAM_WrDatVld,
    input  logic                       DRAM_WrDatRdy,
    output logic                       Busy
`ifdef ITFRSP_LEN_CHECK_EN
    ,
    output logic                       ErrLen
`endif
);
    import itf_pkg::*;

    localparam int c_ratio    = SRAM_WIDTH / PORT_WIDTH;
    localparam int c_ratio_lg = $clog2(c_ratio);
    localparam int c_tw       = NUM_WIDTH + c_ratio_lg;
    localparam int c_bpb      = bytes_per_beat(PORT_WIDTH);
    localparam int c_infl_w   = FIFO_AW + 2;
    localparam logic [c_infl_w-1:0] c_depth = c_infl_w'(1 << FIFO_AW);

    logic [1:0]                 r_state;
    logic [1:0]                 w_next_state;
    logic [DRAM_ADDR_WIDTH-1:0] r_base;
    logic [c_tw-1:0]            r_tot;
    logic [c_tw-1:0]            r_issued;
    logic [c_tw-1:0]            r_sent;
    logic [FIFO_AW:0]           r_outst;

    logic                       w_cmd_fire;
    logic                       w_cmd_out;
    logic [NUM_WIDTH-1:0]       w_cmd_num;
    logic [DRAM_ADDR_WIDTH-1:0] w_cmd_base;
    logic [c_tw-1:0]            w_cmd_tot;
    logic                       w_abort;
    logic [c_infl_w-1:0]        w_inflight;
    logic                       w_rd_req;
    logic                       w_rd_fire;
    logic                       w_push;
    logic                       w_beat_vld;
    logic                       w_beat_fire;
    logic                       w_beat_last;
    logic                       w_wr_vld;
    logic                       w_wr_fire;
    logic                       w_flush;
    logic [DRAM_ADDR_WIDTH-1:0] w_addr;
    logic [PORT_WIDTH-1:0]      w_fifo_dout;
    logic                       w_fifo_empty;
    logic [FIFO_AW:0]           w_fifo_count;

    assign w_cmd_out  = GICITF_Dat[INOUT_LSB];
    assign w_cmd_base = GICITF_Dat[ADDR_LSB +: DRAM_ADDR_WIDTH];
    assign w_cmd_num  = GICITF_Dat[NUM_LSB +: NUM_WIDTH];
    assign w_cmd_tot  = c_tw'(w_cmd_num) << c_ratio_lg;

    assign w_cmd_fire = (r_state == IDLE) && GICITF_CmdVld && GICITF_DatVld;
    assign w_abort    = GICITF_CmdVld && ((r_state == RD) || (r_state == WR));

    // Issued-but-unreturned reads plus queued beats never exceed the FIFO depth,
    // so returns can always be accepted without back-pressure.
    assign w_inflight = c_infl_w'(r_outst) + c_infl_w'(w_fifo_count);
    assign w_rd_req   = (r_state == RD) && !GICITF_CmdVld
                        && (r_issued < r_tot) && (w_inflight < c_depth);
    assign w_rd_fire  = w_rd_req && DRAM_RdAddrRdy;
    assign w_push     = DRAM_RdDatVld && (r_state == RD);

    assign w_beat_vld  = (r_state == RD) && !w_fifo_empty && !GICITF_CmdVld;
    assign w_beat_fire = w_beat_vld && GICITF_DatRdy;
    assign w_beat_last = (r_sent == (r_tot - c_tw'(1)));

    // A command beat arriving mid-write is an abort, never write data.
    assign w_wr_vld  = (r_state == WR) && GICITF_DatVld && !GICITF_CmdVld;
    assign w_wr_fire = w_wr_vld && DRAM_WrDatRdy;

    assign w_flush = (r_state == DRAIN) && (r_outst == '0);

    // r_issued doubles as the write beat index while in WR.
    assign w_addr = r_base + (DRAM_ADDR_WIDTH'(r_issued) * DRAM_ADDR_WIDTH'(c_bpb));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire && (w_cmd_num != '0)) begin
                    w_next_state = w_cmd_out ? WR : RD;
                end
            end
            RD: begin
                if (w_abort)                         w_next_state = DRAIN;
                else if (w_beat_fire && w_beat_last) w_next_state = IDLE;
            end
            WR: begin
                if (w_abort)                          w_next_state = DRAIN;
                else if (w_wr_fire && GICITF_DatLast) w_next_state = IDLE;
            end
            DRAIN: begin
                if (r_outst == '0) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        ITFGIC_DatRdy  = 1'b0;
        ITFGIC_DatVld  = 1'b0;
        ITFGIC_DatLast = 1'b0;
        DRAM_RdAddrVld = 1'b0;
        DRAM_WrDatVld  = 1'b0;
        Busy           = (r_state != IDLE);
        case (r_state)
            IDLE: ITFGIC_DatRdy = 1'b1;
            RD: begin
                ITFGIC_DatVld  = w_beat_vld;
                ITFGIC_DatLast = w_beat_vld && w_beat_last;
                DRAM_RdAddrVld = w_rd_req;
            end
            WR: begin
                ITFGIC_DatRdy = DRAM_WrDatRdy && !GICITF_CmdVld;
                DRAM_WrDatVld = w_wr_vld;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base   <= '0;
            r_tot    <= '0;
            r_issued <= '0;
            r_sent   <= '0;
        end else if (w_cmd_fire) begin
            r_base   <= w_cmd_base;
            r_tot    <= w_cmd_tot;
            r_issued <= '0;
            r_sent   <= '0;
        end else begin
            if (w_rd_fire || w_wr_fire) r_issued <= r_issued + c_tw'(1);
            if (w_beat_fire)            r_sent   <= r_sent + c_tw'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outst <= '0;
        end else begin
            case ({w_rd_fire, DRAM_RdDatVld && (r_outst != '0)})
                2'b10:   r_outst <= r_outst + (FIFO_AW+1)'(1);
                2'b01:   r_outst <= r_outst - (FIFO_AW+1)'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

    FIFO_FWFT #(
        .DATA_WIDTH (PORT_WIDTH),
        .ADDR_WIDTH (FIFO_AW)
    ) u_ret_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_din   (DRAM_RdDat),
        .i_pop   (w_beat_fire),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign ITFGIC_Dat  = w_fifo_dout;
    assign DRAM_RdAddr = w_addr;
    assign DRAM_WrAddr = w_addr;
    assign DRAM_WrDat  = GICITF_Dat;

`ifdef ITFRSP_LEN_CHECK_EN
    logic r_err_len;
    logic w_len_bad;

    // Last must land exactly on beat TOT-1, and beat TOT-1 must carry Last.
    assign w_len_bad = w_wr_fire && (GICITF_DatLast != (r_issued == (r_tot - c_tw'(1))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_len <= 1'b0;
        end else if (w_cmd_fire) begin
            r_err_len <= 1'b0;
        end else if (w_len_bad) begin
            r_err_len <= 1'b1;
        end
    end

    assign ErrLen = r_err_len;
`endif

endmodule
`default_nettype wire

// File: tb/tb_itf_dram_responder.sv
`default_nettype none
// Directed-random bench for itf_dram_responder: DRAM and GIC modelled in-bench,
// expectations derived from command fields with plain address arithmetic.
`timescale 1ns/1ps
module tb_itf_dram_responder;
    localparam int PW = 128;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          GICITF_CmdVld, GICITF_DatVld, GICITF_DatLast, GICITF_DatRdy;
    logic [PW-1:0] GICITF_Dat;
    logic          ITFGIC_DatRdy, ITFGIC_DatVld, ITFGIC_DatLast;
    logic [PW-1:0] ITFGIC_Dat;
    logic [AW-1:0] DRAM_RdAddr, DRAM_WrAddr;
    logic          DRAM_RdAddrVld, DRAM_RdAddrRdy, DRAM_RdDatVld;
    logic [PW-1:0] DRAM_RdDat, DRAM_WrDat;
    logic          DRAM_WrDatVld, DRAM_WrDatRdy;
    logic          Busy;
`ifdef ITFRSP_LEN_CHECK_EN
    logic          ErrLen;
`endif

    always #5 clk = ~clk;

    itf_dram_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .GICITF_CmdVld  (GICITF_CmdVld),
        .GICITF_Dat     (GICITF_Dat),
        .GICITF_DatVld  (GICITF_DatVld),
        .GICITF_DatLast (GICITF_DatLast),
        .ITFGIC_DatRdy  (ITFGIC_DatRdy),
        .ITFGIC_Dat     (ITFGIC_Dat),
        .ITFGIC_DatVld  (ITFGIC_DatVld),
        .ITFGIC_DatLast (ITFGIC_DatLast),
        .GICITF_DatRdy  (GICITF_DatRdy),
        .DRAM_RdAddr    (DRAM_RdAddr),
        .DRAM_RdAddrVld (DRAM_RdAddrVld),
        .DRAM_RdAddrRdy (DRAM_RdAddrRdy),
        .DRAM_RdDat     (DRAM_RdDat),
        .DRAM_RdDatVld  (DRAM_RdDatVld),
        .DRAM_WrAddr    (DRAM_WrAddr),
        .DRAM_WrDat     (DRAM_WrDat),
        .DRAM_WrDatVld  (DRAM_WrDatVld),
        .DRAM_WrDatRdy  (DRAM_WrDatRdy),
        .Busy           (Busy)
`ifdef ITFRSP_LEN_CHECK_EN
        ,
        .ErrLen         (ErrLen)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // environment knobs: 0 = always ready, 1 = toggle, 2 = random
    int rd_rdy_mode, gic_rdy_mode, wr_rdy_mode;
    int lat_fixed;      // 0 selects a random latency 1..5
    int last_due = 0;
    int n_rd, n_beat, max_infl;
    bit cmd_acc, wr_acc;

    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] ret_addr_q[$];
    int            ret_due_q[$];
    logic [PW-1:0] beat_q[$];
    bit            beat_last_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [PW-1:0] wr_dat_q[$];

    function automatic logic [PW-1:0] dat_of(input logic [AW-1:0] a);
        return {a ^ 32'hA5A5_5A5A, ~a, a + 32'h0101_0101, a ^ 32'hC0DE_0000};
    endfunction

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base, input int k);
        return base + 32'(k) * 32'd16;
    endfunction

    function automatic bit rdy_of(input int mode);
        if (mode == 1) return bit'(cyc % 2);
        if (mode == 2) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, sample handshakes 1ns later.
    task automatic step(input logic cv, input logic [PW-1:0] d, input logic dv, input logic dl);
        int due;
        @(negedge clk);
        GICITF_CmdVld  = cv;
        GICITF_Dat     = d;
        GICITF_DatVld  = dv;
        GICITF_DatLast = dl;
        DRAM_RdAddrRdy = rdy_of(rd_rdy_mode);
        GICITF_DatRdy  = rdy_of(gic_rdy_mode);
        DRAM_WrDatRdy  = rdy_of(wr_rdy_mode);
        if (ret_due_q.size() > 0 && ret_due_q[0] <= cyc) begin
            DRAM_RdDatVld = 1'b1;
            DRAM_RdDat    = dat_of(ret_addr_q[0]);
            void'(ret_due_q.pop_front());
            void'(ret_addr_q.pop_front());
        end else begin
            DRAM_RdDatVld = 1'b0;
            DRAM_RdDat    = {$urandom, $urandom, $urandom, $urandom};
        end
        #1;
        cmd_acc = cv && dv && ITFGIC_DatRdy;
        if (DRAM_RdAddrVld && DRAM_RdAddrRdy) begin
            rd_q.push_back(DRAM_RdAddr);
            ret_addr_q.push_back(DRAM_RdAddr);
            due = cyc + ((lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 5)));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            ret_due_q.push_back(due);
            n_rd++;
        end
        if (ITFGIC_DatVld && GICITF_DatRdy) begin
            beat_q.push_back(ITFGIC_Dat);
            beat_last_q.push_back(ITFGIC_DatLast);
            n_beat++;
        end
        wr_acc = DRAM_WrDatVld && DRAM_WrDatRdy;
        if (wr_acc) begin
            wr_addr_q.push_back(DRAM_WrAddr);
            wr_dat_q.push_back(DRAM_WrDat);
        end
        if (n_rd - n_beat > max_infl) max_infl = n_rd - n_beat;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    endtask

    task automatic clear_logs();
        rd_q.delete(); beat_q.delete(); beat_last_q.delete();
        wr_addr_q.delete(); wr_dat_q.delete();
        n_rd = 0; n_beat = 0; max_infl = 0;
    endtask

    task automatic send_cmd(input string tag, input bit out, input logic [31:0] base,
                            input logic [15:0] num, output int tries);
        logic [PW-1:0] c;
        c        = '0;
        c[0]     = out;
        c[32:1]  = base;
        c[48:33] = num;
        tries    = 0;
        do begin
            step(1'b1, c, 1'b1, 1'b1);
            tries++;
        end while (!cmd_acc && tries < 60);
        chk({tag, "_cmd_accepted"}, PW'(cmd_acc), PW'(1));
    endtask

    task automatic check_rd(input string tag, input logic [31:0] base, input int tot);
        chk({tag, "_n_reads"}, PW'(rd_q.size()), PW'(tot));
        chk({tag, "_n_beats"}, PW'(beat_q.size()), PW'(tot));
        for (int k = 0; k < tot && k < rd_q.size(); k++)
            chk($sformatf("%s_rdaddr%0d", tag, k), PW'(rd_q[k]), PW'(beat_addr(base, k)));
        for (int k = 0; k < tot && k < beat_q.size(); k++) begin
            chk($sformatf("%s_beat%0d", tag, k), beat_q[k], dat_of(beat_addr(base, k)));
            chk($sformatf("%s_last%0d", tag, k), PW'(beat_last_q[k]), PW'(k == tot - 1));
        end
    endtask

    task automatic run_rd(input string tag, input logic [31:0] base, input logic [15:0] num);
        int tries, guard;
        clear_logs();
        send_cmd(tag, 1'b0, base, num, tries);
        idle();
        chk({tag, "_busy"}, PW'(Busy), PW'(1));
        guard = 0;
        while (beat_q.size() < 2 * int'(num) && guard < 600) begin
            idle();
            guard++;
        end
        idle();
        chk({tag, "_idle_after"}, PW'(Busy), PW'(0));
        check_rd(tag, base, 2 * int'(num));
    endtask

    task automatic wr_beats(input string tag, input logic [31:0] base, input int last_at);
        logic [PW-1:0] exp_d[$];
        logic [PW-1:0] d;
        int guard;
        for (int k = 0; k <= last_at; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            exp_d.push_back(d);
            guard = 0;
            do begin
                step(1'b0, d, 1'b1, k == last_at);
                guard++;
            end while (!wr_acc && guard < 60);
        end
        idle();
        chk({tag, "_idle_after"}, PW'(Busy), PW'(0));
        chk({tag, "_n_writes"}, PW'(wr_addr_q.size()), PW'(last_at + 1));
        for (int k = 0; k <= last_at && k < wr_addr_q.size(); k++) begin
            chk($sformatf("%s_wraddr%0d", tag, k), PW'(wr_addr_q[k]), PW'(beat_addr(base, k)));
            chk($sformatf("%s_wrdat%0d", tag, k), wr_dat_q[k], exp_d[k]);
        end
    endtask

    initial begin
        int tries, guard, rd_at_abort, beat_at_abort;
        bit busy_seen;
        rst_n          = 1'b0;
        GICITF_CmdVld  = 1'b0;
        GICITF_Dat     = '0;
        GICITF_DatVld  = 1'b0;
        GICITF_DatLast = 1'b0;
        GICITF_DatRdy  = 1'b1;
        DRAM_RdAddrRdy = 1'b1;
        DRAM_RdDat     = '0;
        DRAM_RdDatVld  = 1'b0;
        DRAM_WrDatRdy  = 1'b1;
        rd_rdy_mode = 0; gic_rdy_mode = 0; wr_rdy_mode = 0; lat_fixed = 3;
        clear_logs();

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", PW'(Busy), PW'(0));
        chk("rst_datrdy", PW'(ITFGIC_DatRdy), PW'(1));
        chk("rst_outvld", PW'({ITFGIC_DatVld, ITFGIC_DatLast, DRAM_RdAddrVld, DRAM_WrDatVld}), PW'(0));
`ifdef ITFRSP_LEN_CHECK_EN
        chk("rst_errlen", PW'(ErrLen), PW'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // 1: IN2CHIP Num=2, base 0x1000, latency 3
        run_rd("t1", 32'h0000_1000, 16'd2);

        // 2: OUT2OFF Num=3 across the 32-bit address wrap
        wr_rdy_mode = 2;
        clear_logs();
        send_cmd("t2", 1'b1, 32'hFFFF_FFF0, 16'd3, tries);
        wr_beats("t2", 32'hFFFF_FFF0, 5);
`ifdef ITFRSP_LEN_CHECK_EN
        chk("t2_errlen", PW'(ErrLen), PW'(0));
`endif

        // 4: abort mid-read, then an OUT2OFF command
        clear_logs();
        wr_rdy_mode = 0;
        send_cmd("t4", 1'b0, 32'h0000_2000, 16'd4, tries);
        guard = 0;
        while (n_beat < 3 && guard < 200) begin
            idle();
            guard++;
        end
        chk("t4_reads_in_flight", PW'(ret_due_q.size() != 0), PW'(1));
        rd_at_abort   = n_rd;
        beat_at_abort = n_beat;
        send_cmd("t4_next", 1'b1, 32'h0000_3000, 16'd1, tries);
        chk("t4_returns_absorbed", PW'(ret_due_q.size()), PW'(0));
        chk("t4_no_reads_after_abort", PW'(n_rd), PW'(rd_at_abort));
        chk("t4_no_beats_after_abort", PW'(n_beat), PW'(beat_at_abort));
        chk("t4_waited_for_drain", PW'(tries > 1), PW'(1));
        for (int k = 0; k < beat_at_abort; k++)
            chk($sformatf("t4_beat%0d", k), beat_q[k], dat_of(beat_addr(32'h2000, k)));
        wr_beats("t4_wr", 32'h0000_3000, 1);

        // 3: IN2CHIP Num=8 with toggling chip ready and random DRAM timing
        rd_rdy_mode = 2; gic_rdy_mode = 1; lat_fixed = 0;
        run_rd("t3", 32'h0001_0000, 16'd8);
        chk("t3_inflight_le_4", PW'(max_infl <= 4), PW'(1));

        // 5: Num=0 command
        clear_logs();
        gic_rdy_mode = 2; wr_rdy_mode = 2;
        send_cmd("t5", 1'b0, 32'h0000_4000, 16'd0, tries);
        chk("t5_one_cycle", PW'(tries), PW'(1));
        busy_seen = 1'b0;
        repeat (6) begin
            idle();
            if (Busy) busy_seen = 1'b1;
        end
        chk("t5_stays_idle", PW'(busy_seen), PW'(0));
        chk("t5_no_dram", PW'(rd_q.size() + wr_addr_q.size() + beat_q.size()), PW'(0));

        // extra random read after all the above: leftover FIFO data would show here
        run_rd("t7", 32'h8000_0040 + 32'($urandom_range(0, 15)) * 32'd16, 16'($urandom_range(1, 5)));

`ifdef ITFRSP_LEN_CHECK_EN
        // 6: OUT2OFF Num=2 with Last on beat 3 sets ErrLen, next command clears it
        clear_logs();
        send_cmd("t6", 1'b1, 32'h0000_5000, 16'd2, tries);
        wr_beats("t6", 32'h0000_5000, 2);
        chk("t6_errlen_set", PW'(ErrLen), PW'(1));
        send_cmd("t6_clr", 1'b0, 32'h0000_6000, 16'd0, tries);
        idle();
        chk("t6_errlen_clr", PW'(ErrLen), PW'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
